spi_frame_writer: RTL and testbench

Sits directly downstream of the SPI slave byte receiver. It consumes the received bytes (data/valid) and the transfer framing strobes (sot/eot) and groups the bytes into pixels. Each pixel is written into the back half of a double-buffered framebuffer RAM. At the end of a transfer it requests a buffer flip, which is committed only at the display scanner's next vsync.

---
 rtl/spi_frame_writer.sv | 181 ++++++++++++++++++
 tb/tb_spi_frame_writer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_writer.sv
// spi_frame_writer: groups bytes from the SPI slave receiver into pixels and
// writes them into the back half of a double-buffered framebuffer. At the end
// of a transfer it requests a buffer flip, which is committed on the next vsync.
module spi_frame_writer #(
  parameter int WIDTH     = 32,
  parameter int HEIGHT    = 16,
  parameter int BPP_BYTES = 3,
  parameter int PIX_BITS  = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             data,
  input  logic                   valid,
  input  logic                   sot,
  input  logic                   eot,
  input  logic                   vsync,
  output logic                   wr_en,
  output logic [PIX_BITS:0]      wr_addr,
  output logic [8*BPP_BYTES-1:0] wr_data,
  output logic                   front_sel,
  output logic                   flip,
  output logic                   busy,
  output logic                   overflow
);

  localparam int NPIX     = WIDTH * HEIGHT;
  localparam int CNT_BITS = PIX_BITS + 1;
  localparam int PW       = 8 * BPP_BYTES;

  // The pixel counter is one bit wider than the address so it can hold
  // WIDTH*HEIGHT itself, which is the saturated "frame full" value.
  localparam logic [CNT_BITS-1:0] NPIX_C    = CNT_BITS'(NPIX);
  localparam logic [1:0]          LAST_BYTE = 2'(BPP_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    FLIP_PEND
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_BITS-1:0]   pix_cnt_q, pix_cnt_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [PW-1:0]         shift_q, shift_d;
  logic                  eot_q, eot_d;
  logic                  front_sel_q, front_sel_d;
  logic                  wr_en_q, wr_en_d;
  logic [PIX_BITS:0]     wr_addr_q, wr_addr_d;
  logic [PW-1:0]         wr_data_q, wr_data_d;
  logic                  flip_q, flip_d;
  logic                  overflow_q, overflow_d;

  logic                  take_byte;
  logic                  restart;
  logic                  eot_rise;
  logic [CNT_BITS-1:0]   cur_pix;
  logic [1:0]            cur_byte;
  logic [PW-1:0]         cur_shift;
  logic [PW+7:0]         shift_ext;
  logic [PW-1:0]         assembled;

  // Next-state logic: byte acceptance, pixel completion, eot handling and flip commit
  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    byte_idx_d  = byte_idx_q;
    shift_d     = shift_q;
    eot_d       = eot;
    front_sel_d = front_sel_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    flip_d      = 1'b0;
    overflow_d  = overflow_q;
    take_byte   = 1'b0;
    restart     = 1'b0;
    eot_rise    = eot & ~eot_q;
    cur_pix     = pix_cnt_q;
    cur_byte    = byte_idx_q;
    cur_shift   = shift_q;
    shift_ext   = '0;
    assembled   = '0;

    case (state_q)
      IDLE: begin
        if (valid && sot) begin
          take_byte = 1'b1;
          restart   = 1'b1;
          state_d   = RECV;
        end
      end
      RECV: begin
        if (valid) begin
          take_byte = 1'b1;
          restart   = sot;
        end
      end
      FLIP_PEND: begin
        // Bytes arriving here belong to a transfer we cannot store; drop them.
        if (vsync) begin
          front_sel_d = ~front_sel_q;
          flip_d      = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A start-of-transfer byte always begins pixel 0 from scratch.
    if (restart) begin
      cur_pix    = '0;
      cur_byte   = '0;
      cur_shift  = '0;
      overflow_d = 1'b0;
    end

    if (take_byte) begin
      shift_ext = {cur_shift, data};
      assembled = shift_ext[PW-1:0];
      shift_d   = assembled;
      pix_cnt_d = cur_pix;
      if (cur_byte == LAST_BYTE) begin
        byte_idx_d = '0;
        if (cur_pix == NPIX_C) begin
          overflow_d = 1'b1;
        end else begin
          wr_en_d   = 1'b1;
          wr_data_d = assembled;
          wr_addr_d = {~front_sel_q, cur_pix[PIX_BITS-1:0]};
          pix_cnt_d = cur_pix + CNT_BITS'(1);
        end
      end else begin
        byte_idx_d = cur_byte + 2'd1;
      end
    end

    // End of transfer: drop any partial pixel; only flip if something was written.
    if (state_q == RECV && eot_rise) begin
      byte_idx_d = '0;
      state_d    = (pix_cnt_d != '0) ? FLIP_PEND : IDLE;
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pix_cnt_q   <= '0;
      byte_idx_q  <= '0;
      shift_q     <= '0;
      eot_q       <= 1'b1;
      front_sel_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      flip_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      byte_idx_q  <= byte_idx_d;
      shift_q     <= shift_d;
      eot_q       <= eot_d;
      front_sel_q <= front_sel_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      flip_q      <= flip_d;
      overflow_q  <= overflow_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign front_sel = front_sel_q;
  assign flip      = flip_q;
  assign busy      = (state_q == FLIP_PEND);
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_spi_frame_writer.sv
// tb_spi_frame_writer: directed and randomized transfers into spi_frame_writer,
// with expected framebuffer writes derived from the byte stream of each transfer.
module tb_spi_frame_writer;

  localparam int WIDTH    = 32;
  localparam int HEIGHT   = 16;
  localparam int BPP      = 3;
  localparam int PIX_BITS = 9;
  localparam int NPIX     = WIDTH * HEIGHT;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [7:0]           data;
  logic                 valid;
  logic                 sot;
  logic                 eot;
  logic                 vsync;
  logic                 wr_en;
  logic [PIX_BITS:0]    wr_addr;
  logic [8*BPP-1:0]     wr_data;
  logic                 front_sel;
  logic                 flip;
  logic                 busy;
  logic                 overflow;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  logic [7:0]           tx_bytes[$];
  int                   tx_cyc[$];
  logic [PIX_BITS:0]    got_addr[$];
  logic [8*BPP-1:0]     got_data[$];
  int                   got_cyc[$];
  logic [PIX_BITS:0]    exp_addr[$];
  logic [8*BPP-1:0]     exp_data[$];
  int                   exp_cyc[$];

  logic exp_front = 1'b0;
  logic exp_pend  = 1'b0;
  logic exp_ovf   = 1'b0;

  spi_frame_writer #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .BPP_BYTES(BPP), .PIX_BITS(PIX_BITS)
  ) dut (
    .clk(clk), .rst(rst), .data(data), .valid(valid), .sot(sot), .eot(eot),
    .vsync(vsync), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .front_sel(front_sel), .flip(flip), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every framebuffer write, tagged with the cycle it was seen in
  always @(negedge clk) begin
    if (wr_en) begin
      got_addr.push_back(wr_addr);
      got_data.push_back(wr_data);
      got_cyc.push_back(cyc);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input logic s);
    @(negedge clk);
    data  = b;
    sot   = s;
    valid = 1'b1;
    tx_cyc.push_back(cyc);
    @(negedge clk);
    valid = 1'b0;
    sot   = 1'b0;
  endtask

  // Send tx_bytes as one transfer and predict its writes from the byte stream
  task automatic applyStimulus(input logic vs_with_eot);
    int npix;
    int nwr;
    logic [8*BPP-1:0] pw;
    @(negedge clk);
    eot = 1'b0;
    tx_cyc.delete();
    foreach (tx_bytes[i]) sendByte(tx_bytes[i], (i == 0));
    @(negedge clk);
    eot   = 1'b1;
    vsync = vs_with_eot;
    @(negedge clk);
    vsync = 1'b0;
    if (!exp_pend) begin
      npix = tx_bytes.size() / BPP;
      nwr  = (npix > NPIX) ? NPIX : npix;
      for (int p = 0; p < nwr; p++) begin
        pw = '0;
        for (int k = 0; k < BPP; k++) pw = {pw[8*BPP-9:0], tx_bytes[p*BPP+k]};
        exp_addr.push_back({~exp_front, PIX_BITS'(p)});
        exp_data.push_back(pw);
        exp_cyc.push_back(tx_cyc[p*BPP+BPP-1] + 1);
      end
      exp_ovf  = (npix > NPIX);
      exp_pend = (npix > 0);
    end
  endtask

  task automatic randomBytes(input int n);
    tx_bytes.delete();
    for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom));
  endtask

  task automatic checkWrites(input string tag);
    int n;
    repeat (2) @(negedge clk);
    checkOutput({tag, "_nwrites"}, 32'(got_addr.size()), 32'(exp_addr.size()));
    n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_addr[%0d]", tag, i), 32'(got_addr[i]), 32'(exp_addr[i]));
      checkOutput($sformatf("%s_data[%0d]", tag, i), 32'(got_data[i]), 32'(exp_data[i]));
      checkOutput($sformatf("%s_cycle[%0d]", tag, i), got_cyc[i], exp_cyc[i]);
    end
    checkOutput({tag, "_busy"}, 32'(busy), 32'(exp_pend));
    checkOutput({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
    checkOutput({tag, "_front_sel"}, 32'(front_sel), 32'(exp_front));
    got_addr.delete(); got_data.delete(); got_cyc.delete();
    exp_addr.delete(); exp_data.delete(); exp_cyc.delete();
  endtask

  task automatic holdBusy(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput($sformatf("%s_busy_hold[%0d]", tag, i), 32'(busy), 32'(exp_pend));
    end
  endtask

  task automatic pulseVsync(input string tag);
    logic exp_flip;
    @(negedge clk);
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    exp_flip = exp_pend;
    if (exp_pend) begin
      exp_front = ~exp_front;
      exp_pend  = 1'b0;
    end
    checkOutput({tag, "_flip"}, 32'(flip), 32'(exp_flip));
    checkOutput({tag, "_front_sel"}, 32'(front_sel), 32'(exp_front));
    checkOutput({tag, "_busy_after_vsync"}, 32'(busy), 32'(0));
    @(negedge clk);
    checkOutput({tag, "_flip_one_cycle"}, 32'(flip), 32'(0));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_wr_en"}, 32'(wr_en), 32'(0));
    checkOutput({tag, "_wr_addr"}, 32'(wr_addr), 32'(0));
    checkOutput({tag, "_wr_data"}, 32'(wr_data), 32'(0));
    checkOutput({tag, "_front_sel"}, 32'(front_sel), 32'(0));
    checkOutput({tag, "_flip"}, 32'(flip), 32'(0));
    checkOutput({tag, "_busy"}, 32'(busy), 32'(0));
    checkOutput({tag, "_overflow"}, 32'(overflow), 32'(0));
  endtask

  initial begin
    rst   = 1'b0;
    data  = 8'h00;
    valid = 1'b0;
    sot   = 1'b0;
    eot   = 1'b1;
    vsync = 1'b0;
    #3;
    checkAllZero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Single pixel 12 34 56 lands in back buffer 1 at index 0
    tx_bytes = '{8'h12, 8'h34, 8'h56};
    applyStimulus(1'b0);
    repeat (2) @(negedge clk);
    checkOutput("t1_data_const", (got_data.size() > 0) ? 32'(got_data[0]) : 32'hFFFF_FFFF, 32'h0012_3456);
    checkOutput("t1_addr_const", (got_addr.size() > 0) ? 32'(got_addr[0]) : 32'hFFFF_FFFF, 32'h0000_0200);
    checkWrites("t1");
    pulseVsync("t1");

    // Full frame into buffer 0, busy held across a 10-cycle wait for vsync
    randomBytes(NPIX * BPP);
    applyStimulus(1'b0);
    repeat (2) @(negedge clk);
    checkOutput("full_last_addr", (got_addr.size() > 0) ? 32'(got_addr[$]) : 32'hFFFF_FFFF, 32'h0000_01FF);
    checkWrites("full");
    holdBusy("full", 10);
    pulseVsync("full");

    // One pixel too many: saturates and flags overflow
    randomBytes((NPIX + 1) * BPP);
    applyStimulus(1'b0);
    checkWrites("ovf");
    pulseVsync("ovf");

    // 4 bytes with vsync coincident with the eot edge: one write, flip must wait
    randomBytes(4);
    applyStimulus(1'b1);
    checkOutput("eot_vsync_no_flip", 32'(flip), 32'(0));
    checkWrites("four");

    // Transfer while the flip is pending is dropped entirely
    randomBytes(6);
    applyStimulus(1'b0);
    checkWrites("pend_drop");
    pulseVsync("four");

    // Two bytes only: no write, no flip request
    randomBytes(2);
    applyStimulus(1'b0);
    checkWrites("short");
    pulseVsync("short");

    // Random-length transfer
    randomBytes($urandom_range(1, 60));
    applyStimulus(1'b0);
    checkWrites("rand");
    pulseVsync("rand");

    // Leave a non-zero write on the outputs, then reset in the middle of a pixel
    randomBytes(9);
    applyStimulus(1'b0);
    checkWrites("pre_reset");
    pulseVsync("pre_reset");
    @(negedge clk);
    eot = 1'b0;
    sendByte(8'($urandom), 1'b1);
    sendByte(8'($urandom), 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checkAllZero("mid_reset");
    eot = 1'b1;
    exp_front = 1'b0;
    exp_pend  = 1'b0;
    exp_ovf   = 1'b0;
    @(negedge clk);
    got_addr.delete(); got_data.delete(); got_cyc.delete();
    @(negedge clk);
    rst = 1'b1;

    // Fresh transfer after reset writes pixel 0 of buffer 1
    tx_bytes = '{8'hA5, 8'h5A, 8'hC3};
    applyStimulus(1'b0);
    checkWrites("post_reset");
    pulseVsync("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
